// File: rtl/niios_qsys_nios2_ocimem_master.sv
// rtl/niios_qsys_nios2_ocimem_master.sv - JTAG debug memory-access sequencer
// Turns ocimem debug strobes into single-word Avalon-MM transfers with auto-incrementing address.
module niios_qsys_nios2_ocimem_master #(
   parameter int ADDR_W  = 30,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [37:0] jdo,
   input  logic        take_action_ocimem_a,
   input  logic        take_action_ocimem_b,
   input  logic        take_no_action_ocimem_a,
   output logic [31:0] MonDReg,
   output logic        monitor_ready,
   output logic        monitor_error,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
   logic [31:0]         mon_d_q, mon_d_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic                rdy_q, rdy_d;
   logic                any_strobe;
   logic                jdo_unused;

   assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign jdo_unused = &{1'b0, jdo[37:36], jdo[1:0]};

   always_comb begin
      state_d = state_q;
      mon_a_d = mon_a_q;
      mon_d_d = mon_d_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (take_action_ocimem_a) begin
               mon_a_d = jdo[ADDR_W+1:2];
               if (jdo[35]) begin
                  state_d = ST_READ;
                  err_d   = 1'b0;
               end
            end else if (take_action_ocimem_b) begin
               wdata_d = jdo[34:3];
               state_d = ST_WRITE;
               err_d   = 1'b0;
            end else if (take_no_action_ocimem_a) begin
               state_d = ST_READ;
               err_d   = 1'b0;
            end
         end
         ST_READ, ST_WRITE: begin
            // The host should never poke us mid-transfer; flag it but let the transfer finish.
            if (any_strobe) err_d = 1'b1;
            if (!avm_waitrequest) begin
               if (state_q == ST_READ) mon_d_d = avm_readdata;
               mon_a_d = mon_a_q + ADDR_W'(1);
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rd_d  = (state_d == ST_READ);
      wr_d  = (state_d == ST_WRITE);
      rdy_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mon_a_q <= '0;
         mon_d_q <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         mon_a_q <= mon_a_d;
         mon_d_q <= mon_d_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdy_q   <= rdy_d;
      end
   end

   assign MonDReg        = mon_d_q;
   assign monitor_ready  = rdy_q;
   assign monitor_error  = err_q;
   assign avm_address    = 32'({mon_a_q, 2'b00});
   assign avm_read       = rd_q;
   assign avm_write      = wr_q;
   assign avm_writedata  = wdata_q;
   assign avm_byteenable = 4'hF;

endmodule

// File: doc/niios_qsys_nios2_ocimem_master.md
# niios_qsys_nios2_ocimem_master

Debug memory-access sequencer for the Nios II on-chip debug path. It consumes the system-clock-domain JTAG commands (`jdo` and the `take_action_ocimem_*` strobes) and turns them into single-word Avalon-MM reads and writes. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the JTAG debug module wrapper, so the host debugger can peek and poke system memory with auto-incrementing addresses.

## Interface
Parameters:
- `ADDR_W`, default 30: word-address width; the byte address is `{MonAReg, 2'b00}`.
- `TIMEOUT`, default 1024: maximum cycles a request may stall on `avm_waitrequest`; must be ≥2.

Ports:
- `clk`, in, 1: system clock. The block has one clock; everything is synchronous to `clk`.
- `reset`, in, 1: reset, synchronous and active-high.
- `jdo`, in, 38: JTAG data word, valid in the cycle a strobe is high.
- `take_action_ocimem_a`, in, 1: load the address; optionally launch a read.
- `take_action_ocimem_b`, in, 1: write `jdo[34:3]` at `MonAReg`.
- `take_no_action_ocimem_a`, in, 1: read at `MonAReg`.
- `MonDReg`, out, 32: last read data.
- `monitor_ready`, out, 1: high when idle and able to accept a command.
- `monitor_error`, out, 1: sticky error (timeout or command while busy).
- `avm_address`, out, 32: byte address; bits [1:0] are always 0.
- `avm_read`, out, 1: Avalon read request.
- `avm_write`, out, 1: Avalon write request.
- `avm_writedata`, out, 32: write data.
- `avm_byteenable`, out, 4: always 4'hF.
- `avm_readdata`, in, 32: read data, valid in the cycle `avm_read=1` and `avm_waitrequest=0`.
- `avm_waitrequest`, in, 1: slave stall.

## Operation
- **Reset values:** state=IDLE, `MonAReg`=0, `MonDReg`=0, `avm_read`=0, `avm_write`=0, `avm_writedata`=0, `monitor_ready`=1, `monitor_error`=0, timeout counter=0.
- **Command decode in IDLE.** Priority is `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`; a lower-priority strobe in the same cycle is discarded without error.
  - `ocimem_a`: `MonAReg` <= `jdo[ADDR_W+1:2]`.
    - If `jdo[35]`=1: go to READ using the new address.
    - Otherwise: stay in IDLE; `monitor_ready` stays 1.
  - `ocimem_b`: `avm_writedata` <= `jdo[34:3]`; go to WRITE.
  - `no_action_ocimem_a`: go to READ.
- **Error clear.** Any command that launches a transfer clears `monitor_error` in the acceptance cycle.
- **Commands while busy.** A strobe in READ or WRITE is ignored and sets `monitor_error`=1. The transfer in progress continues.
- **READ state.** `avm_read`=1 is held until `avm_waitrequest`=0. On that cycle:
  - `MonDReg` <= `avm_readdata`;
  - `MonAReg` <= `MonAReg`+1;
  - return to IDLE.
- **WRITE state.** Same as READ, using `avm_write`. On completion `MonAReg` increments and `MonDReg` is unchanged.
- **Address increment** wraps modulo 2^ADDR_W: all-ones goes to 0.
- **Timeout.** The counter increments every cycle that a request is asserted and `avm_waitrequest`=1.
  - When the counter equals `TIMEOUT-1` and `avm_waitrequest` is still 1, the request is dropped next cycle and the state returns to IDLE.
  - On abort: `monitor_error`=1, `MonAReg` not incremented, `MonDReg` unchanged.
  - The counter clears on entry to IDLE.
- **Reset mid-transfer.** Reset forces all reset values in the next cycle, and the request deasserts immediately. The bus is expected to be reset alongside this block.

## Timing
- Strobe in cycle N → request (`avm_read` or `avm_write`) high from N+1; `monitor_ready` low from N+1.
- Slave accepts (`avm_waitrequest`=0) in cycle M ≥ N+1:
  - request is low at M+1;
  - `MonDReg`, `MonAReg` and `monitor_ready`=1 are all updated at M+1.
- Zero-wait slave: one cycle of request; `monitor_ready` is low for exactly one cycle.
- Back-to-back operation: a new strobe is accepted in cycle M+1, so the minimum command spacing is 2 cycles.
- Address-only `ocimem_a` (`jdo[35]`=0): `MonAReg` is updated at N+1; no bus activity.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Address load, then read:**
  - Stimulus: `ocimem_a` with `jdo[35]`=0 and address 0x100, then `no_action_ocimem_a`; slave returns 0xCAFEF00D with zero wait.
  - Required: `avm_address`=0x400; `MonDReg`=0xCAFEF00D; `MonAReg`=0x101; `monitor_ready` low for exactly 1 cycle.
- **Write burst with auto-increment:**
  - Stimulus: address 0x10, then three `ocimem_b` writes with data 1, 2, 3; slave waitrequest held 2 cycles on each.
  - Required: writes at byte addresses 0x40, 0x44, 0x48; `avm_byteenable`=F; final `MonAReg`=0x13.
- **Timeout with `TIMEOUT`=8:**
  - Stimulus: read with `avm_waitrequest` stuck at 1.
  - Required: `avm_read` high for exactly 8 cycles; `monitor_error`=1; `MonAReg` unchanged.
  - Follow-up: the next successful read clears `monitor_error`.
- **Busy collision:**
  - Stimulus: `ocimem_b` issued while a read is stalled.
  - Required: the write is never issued; `monitor_error`=1; the read completes normally.
- **Simultaneous strobes and wrap-around:**
  - Stimulus: `ocimem_a` (address 2^ADDR_W−1, `jdo[35]`=1) together with `ocimem_b` in the same cycle.
  - Required: only the read occurs; `MonAReg` wraps to 0.
- **Reset mid-read:**
  - Stimulus: assert `reset` during a stalled read.
  - Required: next cycle `avm_read`=0, `monitor_ready`=1, `MonDReg`=0, `MonAReg`=0.
